sw_debounce: RTL

- Upstream conditioning stage for the slide-switch bank that feeds the priority-encoder / seven-segment display stage.
- Synchronises raw asynchronous SW inputs into the clock domain and debounces each bit independently.
- Presents a clean, glitch-free switch bus plus a one-cycle change strobe. The downstream display stage consumes SW_CLEAN in place of the raw pins.

---
 rtl/sw_debounce_pkg.sv | 8 +
 rtl/sw_debounce_if.sv | 26 ++
 rtl/sw_debounce_debounce_bit.sv | 56 +++++
 rtl/sw_debounce.sv | 47 ++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants for the slide-switch debounce stage.
package sw_debounce_pkg;

    localparam int SW_COUNT              = 9;
    localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
    localparam int DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bus between the raw pins, the debouncer and the display stage.
interface sw_debounce_if
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH = SW_COUNT
) ();

    logic [WIDTH-1:0] SW_RAW;
    logic [WIDTH-1:0] SW_CLEAN;
    logic             SW_CHANGED;

    // Board / stimulus side: drives the pins, observes the clean bus.
    modport master (
        output SW_RAW,
        input  SW_CLEAN,
        input  SW_CHANGED
    );

    // Debouncer side.
    modport slave (
        input  SW_RAW,
        output SW_CLEAN,
        output SW_CHANGED
    );

endinterface

// File: rtl/sw_debounce_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter and clean flop.
// update_evt is combinational and high in the cycle whose edge loads clean.
module sw_debounce_debounce_bit #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic update_evt
);

    localparam int                 CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;

    // Next state: any agreement with clean restarts the count; the update
    // fires on the cycle the counter has already reached its terminal value.
    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        cnt_d      = '0;
        clean_d    = clean_q;
        update_evt = 1'b0;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_MAX) begin
                clean_d    = sync2_q;
                update_evt = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset clears synchroniser, count and clean value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces the slide-switch bank and flags every clean-bus update with a
// single-cycle SW_CHANGED pulse that coincides with the new SW_CLEAN value.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH         = SW_COUNT,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    sw_debounce_if.slave sw
);

    logic [WIDTH-1:0] clean_bits;
    logic [WIDTH-1:0] evt_bits;
    logic             changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk        (CLOCK_50),
            .rst        (RESET),
            .raw        (sw.SW_RAW[i]),
            .clean      (clean_bits[i]),
            .update_evt (evt_bits[i])
        );
    end

    // Any bit updating this edge produces one pulse, however many bits move.
    always_comb begin
        changed_d = |evt_bits;
    end

    // Strobe register, aligned with the clean flops of the bits.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign sw.SW_CLEAN   = clean_bits;
    assign sw.SW_CHANGED = changed_q;

endmodule
